// File: rtl/fir_decim_quant.sv
// Decimate a full-precision fir_out stream, round/saturate kept samples to width bits, buffer in a valid/ready FIFO.
// Optional build macro FIR_DECIM_QUANT_SATCNT_EN adds a 16-bit saturating sat_count output.
module fir_decim_quant #(
    parameter int width = 8,
    parameter int DECIM = 2,
    parameter int SHIFT = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*width-1:0]       in_data,
    input  logic                     in_valid,
    output logic [width-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sat,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
`ifdef FIR_DECIM_QUANT_SATCNT_EN
    ,
    output logic [15:0]              sat_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int RW = 2 * width + 1;
    localparam logic [RW-1:0] HALF = RW'(1) << (SHIFT - 1);

    logic [PW-1:0]    r_phase;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [width-1:0] r_out_data;
    logic             r_sat;
    logic             r_overflow;
    logic [width-1:0] r_mem [DEPTH];

    logic [RW-1:0]    w_round;
    logic [RW-1:0]    w_shift;
    logic             w_over;
    logic [width-1:0] w_q;
    logic             w_keep;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [AW-1:0]    w_rd_ptr_inc;
    logic [width-1:0] w_head_next;
    logic [LW-1:0]    w_level_next;

    // Rounding add is one bit wider than the input so 0xFF80-style values cannot wrap.
    assign w_round = {1'b0, in_data} + HALF;
    assign w_shift = w_round >> SHIFT;
    assign w_over  = |w_shift[RW-1:width];
    assign w_q     = w_over ? {width{1'b1}} : w_shift[width-1:0];

    assign w_keep       = in_valid && (r_phase == '0);
    assign w_pop        = (r_level != '0) && out_ready;
    assign w_push       = w_keep && ((r_level != LW'(DEPTH)) || w_pop);
    assign w_drop       = w_keep && !w_push;
    assign w_rd_ptr_inc = r_rd_ptr + AW'(1);

    // out_data is a register so it reads 0 after reset and holds its last value once empty.
    always_comb begin
        w_head_next = r_out_data;
        if (w_pop) begin
            if (r_level > LW'(1))
                w_head_next = r_mem[w_rd_ptr_inc];
            else if (w_push)
                w_head_next = w_q;
        end else if ((r_level == '0) && w_push) begin
            w_head_next = w_q;
        end
    end

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop)
            w_level_next = r_level + LW'(1);
        else if (!w_push && w_pop)
            w_level_next = r_level - LW'(1);
    end

    // NOTE: storage array has no reset; pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push)
            r_mem[r_wr_ptr] <= w_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_out_data <= '0;
            r_sat      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (in_valid)
                r_phase <= (r_phase == PW'(DECIM - 1)) ? '0 : r_phase + PW'(1);
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= w_rd_ptr_inc;
            r_level    <= w_level_next;
            r_out_data <= w_head_next;
            if (w_keep && w_over)
                r_sat <= 1'b1;
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

`ifdef FIR_DECIM_QUANT_SATCNT_EN
    logic [15:0] r_sat_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_sat_count <= '0;
        else if (w_keep && w_over && (r_sat_count != 16'hFFFF))
            r_sat_count <= r_sat_count + 16'd1;
    end

    assign sat_count = r_sat_count;
`endif

    assign out_data  = r_out_data;
    assign out_valid = (r_level != '0);
    assign sat       = r_sat;
    assign overflow  = r_overflow;
    assign level     = r_level;

endmodule

// File: tb/tb_fir_decim_quant.sv
// Directed bench for fir_decim_quant: one DECIM=1 instance and one default DECIM=2 instance on a shared clock/reset.
`timescale 1ns/1ps
module tb_fir_decim_quant;

    logic        clk = 1'b0;
    logic        rst;

    logic [15:0] a_in_data;
    logic        a_in_valid;
    logic        a_out_ready;
    logic [7:0]  a_out_data;
    logic        a_out_valid;
    logic        a_sat;
    logic        a_overflow;
    logic [2:0]  a_level;

    logic [15:0] b_in_data;
    logic        b_in_valid;
    logic        b_out_ready;
    logic [7:0]  b_out_data;
    logic        b_out_valid;
    logic        b_sat;
    logic        b_overflow;
    logic [2:0]  b_level;

`ifdef FIR_DECIM_QUANT_SATCNT_EN
    logic [15:0] a_sat_count;
    logic [15:0] b_sat_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fir_decim_quant #(.width(8), .DECIM(1), .SHIFT(8), .DEPTH(4)) u_dut_d1 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .sat       (a_sat),
        .overflow  (a_overflow),
        .level     (a_level)
`ifdef FIR_DECIM_QUANT_SATCNT_EN
        ,
        .sat_count (a_sat_count)
`endif
    );

    fir_decim_quant #(.width(8), .DECIM(2), .SHIFT(8), .DEPTH(4)) u_dut_d2 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .sat       (b_sat),
        .overflow  (b_overflow),
        .level     (b_level)
`ifdef FIR_DECIM_QUANT_SATCNT_EN
        ,
        .sat_count (b_sat_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; outputs are settled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic a_push(input logic [15:0] d);
        a_in_data  = d;
        a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        a_in_data   = '0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        b_in_data   = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        #2;
        do_reset();

        check("rst_valid", 32'(a_out_valid), 32'd0);
        check("rst_data",  32'(a_out_data),  32'h00);
        check("rst_level", 32'(a_level),     32'd0);
        check("rst_sat",   32'(a_sat),       32'd0);
        check("rst_ovf",   32'(a_overflow),  32'd0);

        // Rounding at the half-LSB boundary, streaming with out_ready held high.
        a_out_ready = 1'b1;
        a_push(16'h1280);
        check("rnd_up_data",  32'(a_out_data),  32'h13);
        check("rnd_up_valid", 32'(a_out_valid), 32'd1);
        a_push(16'h127F);
        check("rnd_dn_data",  32'(a_out_data),  32'h12);
        check("rnd_dn_level", 32'(a_level),     32'd1);
        a_push(16'h0000);
        check("rnd_zero",     32'(a_out_data),  32'h00);
        check("rnd_sat",      32'(a_sat),       32'd0);
        step();
        check("rnd_empty",    32'(a_out_valid), 32'd0);
        check("rnd_hold",     32'(a_out_data),  32'h00);

        // Saturation and sticky sat.
        a_push(16'hFF80);
        check("sat_data",   32'(a_out_data), 32'hFF);
        check("sat_flag",   32'(a_sat),      32'd1);
        a_push(16'h0100);
        check("sat_next",   32'(a_out_data), 32'h01);
        check("sat_sticky", 32'(a_sat),      32'd1);
`ifdef FIR_DECIM_QUANT_SATCNT_EN
        check("sat_count",  32'(a_sat_count), 32'd1);
`endif
        step();
        do_reset();
        check("sat_cleared", 32'(a_sat), 32'd0);

        // Backpressure: six pushes into a 4-deep FIFO.
        a_out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            a_push(16'(i) << 8);
            if (i == 4) check("bp_ovf_at4", 32'(a_overflow), 32'd0);
        end
        check("bp_level", 32'(a_level),    32'd4);
        check("bp_ovf",   32'(a_overflow), 32'd1);
        check("bp_head",  32'(a_out_data), 32'h01);
        a_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("bp_drain%0d", i), 32'(a_out_data), 32'(i));
            step();
        end
        check("bp_empty_valid", 32'(a_out_valid), 32'd0);
        check("bp_empty_level", 32'(a_level),     32'd0);
        step();
        check("bp_no_underflow", 32'(a_level), 32'd0);

        // Push into a full FIFO on the same edge as a pop.
        do_reset();
        a_out_ready = 1'b0;
        for (int i = 5; i <= 8; i++) a_push(16'(i) << 8);
        check("fp_level_pre", 32'(a_level), 32'd4);
        a_out_ready = 1'b1;
        a_push(16'h0900);
        check("fp_level", 32'(a_level),    32'd4);
        check("fp_ovf",   32'(a_overflow), 32'd0);
        for (int i = 6; i <= 9; i++) begin
            check($sformatf("fp_drain%0d", i), 32'(a_out_data), 32'(i));
            step();
        end
        check("fp_empty", 32'(a_out_valid), 32'd0);

        // Decimation by 2 with continuous in_valid.
        do_reset();
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            b_in_data = 16'(i) << 8;
            step();
            if (i % 2 == 1) begin
                check($sformatf("dec_valid%0d", i), 32'(b_out_valid), 32'd1);
                check($sformatf("dec_data%0d", i),  32'(b_out_data),  32'(i));
            end else begin
                check($sformatf("dec_skip%0d", i),  32'(b_out_valid), 32'd0);
            end
        end
        b_in_valid = 1'b0;

        // Mid-stream reset: level 3 and sat set, with a push presented in the reset cycle.
        a_out_ready = 1'b0;
        a_push(16'hFF80);
        a_push(16'h0100);
        a_push(16'h0200);
        check("mr_level_pre", 32'(a_level), 32'd3);
        check("mr_sat_pre",   32'(a_sat),   32'd1);
        b_out_ready = 1'b0;
        b_in_data   = 16'h0100;
        b_in_valid  = 1'b1;
        step();
        b_in_valid  = 1'b0;
        check("mr_b_level_pre", 32'(b_level), 32'd1);
        a_in_data  = 16'h0300;
        a_in_valid = 1'b1;
        do_reset();
        a_in_valid = 1'b0;
        check("mr_valid", 32'(a_out_valid), 32'd0);
        check("mr_level", 32'(a_level),     32'd0);
        check("mr_sat",   32'(a_sat),       32'd0);
        check("mr_ovf",   32'(a_overflow),  32'd0);
        check("mr_b_level", 32'(b_level),   32'd0);
        b_in_data  = 16'h0A00;
        b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        check("mr_phase_valid", 32'(b_out_valid), 32'd1);
        check("mr_phase_data",  32'(b_out_data),  32'h0A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
